// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider slice.
//   state_t       : controller states IDLE / BUSY / DONE
//   DIV_UNSIGNED  : signed_div value for DIVU (matches the immediate zero-extend select)
//   DIV_SIGNED    : signed_div value for DIV  (matches the immediate sign-extend select)
//   DIV_ZERO_QUO  : quotient delivered when the divisor is zero
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DIV_UNSIGNED = 1'b0;
    localparam logic DIV_SIGNED   = 1'b1;

    localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_ctrl_if.sv
// Decoder <-> divider handshake bundle.
//   start, signed_div, a, b, annul : driven by the decoder (master)
//   busy, valid, hi, lo            : driven by the divider (slave)
interface div_ctrl_if
    import div_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             annul;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, signed_div, a, b, annul,
        input  busy, valid, hi, lo
    );

    modport slave (
        input  start, signed_div, a, b, annul,
        output busy, valid, hi, lo
    );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step.
//   rem_in  : partial remainder (always < divisor for a nonzero divisor)
//   quo_in  : dividend bits still to be shifted in, MSB first; quotient bits fill from the LSB
//   divisor : divisor magnitude
//   rem_out : updated partial remainder
//   quo_out : quo_in shifted left by one with the new quotient bit in bit 0
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // One extra bit keeps the shifted remainder exact; since rem_in < divisor,
    // bit WIDTH of the trial difference is set exactly when it went negative.
    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        if (trial[WIDTH]) begin
            rem_out = shifted[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end else begin
            rem_out = trial[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Sequencing controller for the EX-stage MIPS DIV/DIVU divider.
// Accepts a divide, stalls the pipeline for WIDTH restoring iterations,
// applies the result signs and registers hi (remainder) / lo (quotient).
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : div_ctrl_if.slave (start, signed_div, a, b, annul in; busy, valid, hi, lo out)
// Build option:
//   DIV_ZERO_FAST_EN : when defined, a zero divisor skips BUSY and goes straight to DONE.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands latched on the accepting cycle
// BUSY  | one quotient bit per cycle, counter 0..WIDTH-1, busy=1
// DONE  | sign fix-up, hi/lo written, valid pulses the cycle after
module div_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_ctrl_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [WIDTH-1:0] a_q;
    logic             quo_neg_q;
    logic             rem_neg_q;
    logic             dz_q;

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             valid_q;

    logic             busy;
    logic             load;
    logic             step_en;
    logic             wr_res;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.start && !bus.annul) begin
`ifdef DIV_ZERO_FAST_EN
                    state_nx = (bus.b == '0) ? DONE : BUSY;
`else
                    state_nx = BUSY;
`endif
                end
            end
            BUSY: begin
                if (bus.annul)                      state_nx = IDLE;
                else if (cnt == CW'(WIDTH - 1))     state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == BUSY);
        load    = (state == IDLE) && bus.start && !bus.annul;
        step_en = (state == BUSY) && !bus.annul;
        wr_res  = (state == DONE) && !bus.annul;
    end

    always_ff @(posedge clk) begin
        if (rst)          cnt <= '0;
        else if (step_en) cnt <= cnt + CW'(1);
        else              cnt <= '0;
    end

    // -2^(W-1) negates to itself, which is exactly its unsigned magnitude.
    always_comb begin
        a_mag = bus.a;
        b_mag = bus.b;
        if (bus.signed_div == DIV_SIGNED) begin
            if (bus.a[WIDTH-1]) a_mag = -bus.a;
            if (bus.b[WIDTH-1]) b_mag = -bus.b;
        end
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvsr_q),
        .rem_out (rem_nx),
        .quo_out (quo_nx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            a_q       <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
        end else if (load) begin
            rem_q     <= '0;
            quo_q     <= a_mag;
            dvsr_q    <= b_mag;
            a_q       <= bus.a;
            quo_neg_q <= (bus.signed_div == DIV_SIGNED) && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            rem_neg_q <= (bus.signed_div == DIV_SIGNED) && bus.a[WIDTH-1];
            dz_q      <= (bus.b == '0);
        end else if (step_en) begin
            rem_q     <= rem_nx;
            quo_q     <= quo_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q    <= '0;
            lo_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= wr_res;
            if (wr_res) begin
                if (dz_q) begin
                    lo_q <= DIV_ZERO_QUO[WIDTH-1:0];
                    hi_q <= a_q;
                end else begin
                    lo_q <= quo_neg_q ? -quo_q : quo_q;
                    hi_q <= rem_neg_q ? -rem_q : rem_q;
                end
            end
        end
    end

    assign bus.busy  = busy;
    assign bus.valid = valid_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;
    localparam int WIDTH = 32;

    logic clk;
    logic rst;
    int   total;
    int   passes;
    logic [31:0] last_lo;
    logic [31:0] last_hi;

    div_ctrl_if #(.WIDTH(WIDTH)) bus ();

    div_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer division with the MIPS zero-divisor and overflow rules.
    function automatic void model(input logic sd, input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] el, output logic [31:0] eh);
        int sa;
        int sb;
        if (bv == 32'd0) begin
            el = 32'hFFFF_FFFF;
            eh = av;
        end else if (sd) begin
            if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
                el = 32'h8000_0000;
                eh = 32'd0;
            end else begin
                sa = int'(av);
                sb = int'(bv);
                el = 32'(sa / sb);
                eh = 32'(sa % sb);
            end
        end else begin
            el = av / bv;
            eh = av % bv;
        end
    endfunction

    task automatic do_div(input logic sd, input logic [31:0] av, input logic [31:0] bv,
                          input int glitch, input string tag);
        logic [31:0] el;
        logic [31:0] eh;
        int          lat;
        int          exp_lat;
        bit          busy_bad;
        bit          exp_busy;
        model(sd, av, bv, el, eh);
        exp_lat = WIDTH + 2;
`ifdef DIV_ZERO_FAST_EN
        if (bv == 32'd0) exp_lat = 2;
`endif
        bus.signed_div = sd;
        bus.a          = av;
        bus.b          = bv;
        bus.start      = 1'b1;
        lat      = 0;
        busy_bad = 1'b0;
        for (int cnt = 1; cnt <= 60; cnt++) begin
            tick();
            exp_busy = (exp_lat == WIDTH + 2) && (cnt <= WIDTH);
            if (bus.busy !== exp_busy) busy_bad = 1'b1;
            if (bus.valid === 1'b1) begin
                lat = cnt;
                break;
            end
            if (cnt == glitch) begin
                bus.start = 1'b1;
                bus.a     = ~av;
                bus.b     = 32'd3;
            end else begin
                bus.start = 1'b0;
                bus.a     = av;
                bus.b     = bv;
            end
        end
        bus.start = 1'b0;
        bus.a     = av;
        bus.b     = bv;
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_busy_window"}, 32'(busy_bad), 32'd0);
        chk({tag, "_lo"}, bus.lo, el);
        chk({tag, "_hi"}, bus.hi, eh);
        tick();
        chk({tag, "_valid_single"}, 32'(bus.valid), 32'd0);
        chk({tag, "_idle_after"}, 32'(bus.busy), 32'd0);
        chk({tag, "_lo_hold"}, bus.lo, el);
        last_lo = el;
        last_hi = eh;
    endtask

    task automatic watch_no_valid(input int n, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.valid !== 1'b0) seen = 1'b1;
        end
        chk({tag, "_no_valid"}, 32'(seen), 32'd0);
        chk({tag, "_hi_kept"}, bus.hi, last_hi);
        chk({tag, "_lo_kept"}, bus.lo, last_lo);
    endtask

    initial begin
        logic [31:0] av;
        logic [31:0] bv;
        logic        sd;
        int          sel;
        total   = 0;
        passes  = 0;
        last_lo = 32'd0;
        last_hi = 32'd0;

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.signed_div = 1'b0;
        bus.a          = 32'd0;
        bus.b          = 32'd0;
        bus.annul      = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        rst = 1'b0;
        tick();

        do_div(1'b0, 32'd100, 32'd7, 0, "divu_100_7");
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, "div_7_m2");
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0, "divu_max_1");
        do_div(1'b0, 32'h0000_1234, 32'd0, 0, "divu_by0");
        do_div(1'b1, 32'h0000_1234, 32'd0, 0, "div_by0");
        do_div(1'b1, 32'hFFFF_FF00, 32'd0, 0, "div_neg_by0");

        // annul in BUSY: back to IDLE, no result, outputs untouched
        bus.signed_div = 1'b0;
        bus.a          = 32'd5000;
        bus.b          = 32'd3;
        bus.start      = 1'b1;
        for (int cnt = 1; cnt <= 10; cnt++) begin
            tick();
            bus.start = 1'b0;
            if (cnt == 10) bus.annul = 1'b1;
        end
        tick();
        chk("annul_idle", 32'(bus.busy), 32'd0);
        bus.annul = 1'b0;
        watch_no_valid(40, "annul");
        do_div(1'b0, 32'd5000, 32'd3, 0, "after_annul");

        // start pulses with other operands mid-BUSY and during DONE are ignored
        do_div(1'b0, 32'd100, 32'd7, 5, "glitch_busy");
        do_div(1'b1, 32'hFFFF_FC18, 32'd9, WIDTH + 1, "glitch_done");

        // reset mid-operation
        bus.signed_div = 1'b0;
        bus.a          = 32'd77777;
        bus.b          = 32'd5;
        bus.start      = 1'b1;
        for (int cnt = 1; cnt <= 20; cnt++) begin
            tick();
            bus.start = 1'b0;
            if (cnt == 20) rst = 1'b1;
        end
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_valid", 32'(bus.valid), 32'd0);
        chk("midrst_hi", bus.hi, 32'd0);
        chk("midrst_lo", bus.lo, 32'd0);
        last_lo = 32'd0;
        last_hi = 32'd0;
        watch_no_valid(40, "midrst");

        // annul together with start in IDLE drops the start
        bus.a     = 32'd50;
        bus.b     = 32'd5;
        bus.start = 1'b1;
        bus.annul = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.annul = 1'b0;
        chk("annul_start_busy", 32'(bus.busy), 32'd0);
        watch_no_valid(5, "annul_start");

        for (int i = 0; i < 20; i++) begin
            sel = int'($urandom_range(0, 7));
            av  = $urandom;
            bv  = $urandom;
            sd  = 1'($urandom_range(0, 1));
            case (sel)
                0: bv = 32'd0;
                1: bv = 32'd1;
                2: bv = 32'hFFFF_FFFF;
                3: begin av = 32'h8000_0000; bv = 32'hFFFF_FFFF; sd = 1'b1; end
                4: bv = 32'($urandom_range(1, 15));
                default: ;
            endcase
            do_div(sd, av, bv, 0, "rand");
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
